// File: rtl/cla_nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead slice per clock, LSB nibble first.
// Optional subtract mode is enabled by defining NIBBLE_SUB_EN.
module cla_nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N    = WIDTH / 4;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       sl_a, sl_b, sl_g, sl_p, sl_s;
    logic [4:0]       sl_c;
    logic [WIDTH+3:0] sum_shift;
    logic             accept;

`ifndef NIBBLE_SUB_EN
    logic unused_sub;
    assign unused_sub = sub;
`endif

    // 4-bit carry-lookahead slice on the low nibble of the shift registers
    always_comb begin
        sl_a    = a_sh_q[3:0];
        sl_b    = b_sh_q[3:0];
        sl_g    = sl_a & sl_b;
        sl_p    = sl_a ^ sl_b;
        sl_c[0] = carry_q;
        sl_c[1] = sl_g[0] | (sl_p[0] & sl_c[0]);
        sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & sl_c[0]);
        sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
                | (sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
        sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
                | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
                | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
        sl_s    = sl_p ^ sl_c[3:0];
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        accept    = 1'b0;
        // Concatenate then drop the low nibble so WIDTH==4 needs no special case
        sum_shift = {sl_s, sum_q};

        unique case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone) begin
                    state_d = StIdle;
                end
                if (start) begin
                    accept  = 1'b1;
                    state_d = StRun;
                    idx_d   = '0;
                    a_sh_d  = a;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
`ifdef NIBBLE_SUB_EN
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
`else
                    b_sh_d  = b;
                    carry_d = cin;
`endif
                end
            end
            StRun: begin
                sum_d   = sum_shift[WIDTH+3:4];
                carry_d = sl_c[4];
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                idx_d   = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                    idx_d   = '0;
                    cout_d  = sl_c[4];
                    ovf_d   = (sl_a[3] == sl_b[3]) & (sl_s[3] != sl_a[3]);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    logic unused_accept;
    assign unused_accept = accept;

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Self-checking bench for cla_nibble_serial_adder (WIDTH=16) against an arithmetic model.
// Subtract scenarios are compiled in only when NIBBLE_SUB_EN is defined.
module tb_cla_nibble_serial_adder;

    localparam int unsigned W = 16;
    localparam int unsigned N = W / 4;

    logic         clk = 1'b0;
    logic         rst, start, cin, sub;
    logic [W-1:0] a, b;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int total = 0;
    int bad   = 0;

    cla_nibble_serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sub  (sub),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mcin, input logic msub,
                                  output logic [W-1:0] msum, output logic mcout,
                                  output logic movf);
        logic [W-1:0] beff;
        logic         c;
        logic [W:0]   full;
        logic         do_sub;
`ifdef NIBBLE_SUB_EN
        do_sub = msub;
`else
        do_sub = 1'b0;
        if (msub) do_sub = 1'b0;
`endif
        beff  = do_sub ? ~mb : mb;
        c     = do_sub ? 1'b1 : mcin;
        full  = {1'b0, ma} + {1'b0, beff} + {{W{1'b0}}, c};
        msum  = full[W-1:0];
        mcout = full[W];
        movf  = (ma[W-1] == beff[W-1]) && (msum[W-1] != ma[W-1]);
    endfunction

    // Issues start and waits for done; returns edges after the accepting edge and busy count
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic ocin,
                         input logic osub, output int lat, output int bcnt);
        a = oa; b = ob; cin = ocin; sub = osub; start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
        lat = 0; bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        total++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va[5] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic [W-1:0] vb[5] = '{16'h4321, 16'h0001, 16'h0000, 16'h0001, 16'h8000};
        logic         vc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] vs[5] = '{16'h5555, 16'h0000, 16'h0000, 16'h8000, 16'h0000};
        logic         vo[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic         vv[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat, bcnt;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vc[i], 1'b0, lat, bcnt);
            total++;
            if (lat != N || bcnt != N) begin
                bad++;
                $display("FAIL directed_latency[%0d]: lat=%0d busy=%0d, want %0d/%0d",
                         i, lat, bcnt, N, N);
            end
            total++;
            if (sum !== vs[i] || cout !== vo[i] || ovf !== vv[i]) begin
                bad++;
                $display("FAIL directed[%0d]: sum=%h cout=%b ovf=%b, want %h %b %b",
                         i, sum, cout, ovf, vs[i], vo[i], vv[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, es;
        logic         rc, rs, ec, eo;
        int lat, bcnt;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom; rc = $urandom; rs = $urandom;
            if (i % 5 == 0) ra = '1;
            model(ra, rb, rc, rs, es, ec, eo);
            do_op(ra, rb, rc, rs, lat, bcnt);
            total++;
            if (lat != N || sum !== es || cout !== ec || ovf !== eo) begin
                bad++;
                $display("FAIL random[%0d] a=%h b=%h cin=%b sub=%b: lat=%0d sum=%h cout=%b ovf=%b, want lat=%0d %h %b %b",
                         i, ra, rb, rc, rs, lat, sum, cout, ovf, N, es, ec, eo);
            end
            tick();
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || sum !== es || cout !== ec || ovf !== eo) begin
                bad++;
                $display("FAIL idle_hold[%0d]: done=%b busy=%b sum=%h cout=%b ovf=%b, want 0 0 %h %b %b",
                         i, done, busy, sum, cout, ovf, es, ec, eo);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        // start during busy with different operands must be ignored
        a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 2;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        total++;
        if (lat != N || sum !== 16'h5555 || cout !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL busy_ignore: lat=%0d sum=%h cout=%b ovf=%b, want lat=%0d 5555 0 0",
                     lat, sum, cout, ovf, N);
        end
        // start in the DONE cycle is accepted; next done follows N+1 edges later
        do_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0, lat, bcnt);
        total++;
        if (lat + 1 != N + 1 || sum !== 16'h1001 || cout !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL back_to_back: gap=%0d sum=%h cout=%b ovf=%b, want gap=%0d 1001 0 0",
                     lat + 1, sum, cout, ovf, N + 1);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int seen;
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            bad++;
            $display("FAIL reset_mid_run: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done || busy) seen++;
            tick();
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_no_done: activity cycles=%0d, want 0", seen);
        end
    endtask

`ifdef NIBBLE_SUB_EN
    task automatic test_sub();
        int lat, bcnt;
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat, bcnt);
        total++;
        if (sum !== 16'hFFFE || cout !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL sub_borrow: sum=%h cout=%b ovf=%b, want fffe 0 0", sum, cout, ovf);
        end
        tick();
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat, bcnt);
        total++;
        if (sum !== 16'h7FFF || cout !== 1'b1 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL sub_ovf: sum=%h cout=%b ovf=%b, want 7fff 1 1", sum, cout, ovf);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
`ifdef NIBBLE_SUB_EN
        test_sub();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
